// File: rtl/median_axis_egress.sv
// Median egress: border substitution and frame tagging into a FIFO with a registered AXI-Stream head; 1-cycle write-to-present.
// o_ready (registered) drops at FIFO_DEPTH-3; writes into a full FIFO are dropped and flagged. Define MEDIAN_EGRESS_STATS_EN for frame/drop counters.
module median_axis_egress #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNELS    = 1,
  parameter int KERNEL_SIZE = 5,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                           i_clk,
  input  logic                           i_areset,
  input  logic [12:0]                    IMG_WIDTH,
  input  logic [12:0]                    IMG_HEIGHT,
  input  logic                           i_border_mode,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_median_pixel,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_raw_pixel,
  input  logic                           i_pixel_valid,
  input  logic                           i_start_of_frame,
  output logic                           o_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tuser,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  output logic                           o_overflow
`ifdef MEDIAN_EGRESS_STATS_EN
  ,
  output logic [15:0]                    o_frame_count,
  output logic [15:0]                    o_drop_count
`endif
);

  localparam int PW = CHANNELS * DATA_WIDTH;
  localparam int EW = PW + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [13:0] B14 = 14'(KERNEL_SIZE / 2);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [12:0]     col_q, col_d, row_q, row_d, w_q, w_d, h_q, h_d;
  logic            ovf_q, ovf_d, ready_q, ready_d;
  logic            head_vld_q, head_vld_d;
  logic [EW-1:0]   head_q, head_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   mem_cnt_q, mem_cnt_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];

  logic            sof_acc, wr, push, pop, drop, head_free, load, bypass, mem_we;
  logic            last_col, last_row, border, first;
  logic [12:0]     eff_w, eff_h, cur_col, cur_row;
  logic [PW-1:0]   wr_dat;
  logic [EW-1:0]   wr_entry;
  logic [CW-1:0]   occ, occ_d;

  // Pixel position and framing, with a start of frame taking effect on its own pixel.
  always_comb begin
    sof_acc  = i_pixel_valid & i_start_of_frame;
    wr       = i_pixel_valid & (sof_acc | (state_q == ACTIVE));
    eff_w    = sof_acc ? IMG_WIDTH  : w_q;
    eff_h    = sof_acc ? IMG_HEIGHT : h_q;
    cur_col  = sof_acc ? 13'd0 : col_q;
    cur_row  = sof_acc ? 13'd0 : row_q;
    last_col = (cur_col == eff_w - 13'd1);
    last_row = (cur_row == eff_h - 13'd1);
    first    = (cur_col == 13'd0) && (cur_row == 13'd0);
    border   = ({1'b0, cur_col} < B14) || (({1'b0, cur_col} + B14) >= {1'b0, eff_w}) ||
               ({1'b0, cur_row} < B14) || (({1'b0, cur_row} + B14) >= {1'b0, eff_h});
    wr_dat   = border ? (i_border_mode ? i_raw_pixel : '0) : i_median_pixel;
    wr_entry = {last_col, first, wr_dat};
  end

  // FIFO: head register in front of a memory; the memory is only used once the head is occupied.
  always_comb begin
    occ       = mem_cnt_q + CW'(head_vld_q);
    pop       = head_vld_q & m_axis_tready;
    push      = wr & ((occ < CW'(FIFO_DEPTH)) | pop);
    drop      = wr & ~push;
    head_free = ~head_vld_q | pop;
    load      = head_free & (mem_cnt_q != '0);
    bypass    = head_free & (mem_cnt_q == '0) & push;
    mem_we    = push & ~bypass;

    head_vld_d = head_vld_q;
    head_d     = head_q;
    if (load) begin
      head_vld_d = 1'b1;
      head_d     = mem_q[rd_ptr_q];
    end else if (bypass) begin
      head_vld_d = 1'b1;
      head_d     = wr_entry;
    end else if (head_free) begin
      head_vld_d = 1'b0;
    end
    rd_ptr_d  = rd_ptr_q + AW'(load);
    wr_ptr_d  = wr_ptr_q + AW'(mem_we);
    mem_cnt_d = mem_cnt_q + CW'(mem_we) - CW'(load);
    occ_d     = mem_cnt_d + CW'(head_vld_d);
    ready_d   = occ_d < CW'(FIFO_DEPTH - 3);
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    w_d     = w_q;
    h_d     = h_q;
    ovf_d   = ovf_q;
    if (sof_acc) begin
      w_d     = IMG_WIDTH;
      h_d     = IMG_HEIGHT;
      ovf_d   = 1'b0;
      state_d = ACTIVE;
    end
    if (wr) begin
      row_d = cur_row;
      if (last_col) begin
        col_d = 13'd0;
        row_d = cur_row + 13'd1;
      end else begin
        col_d = cur_col + 13'd1;
      end
      if (last_col && last_row) begin
        state_d = IDLE;
        col_d   = 13'd0;
        row_d   = 13'd0;
      end
    end
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      w_q        <= '0;
      h_q        <= '0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      mem_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      w_q        <= w_d;
      h_q        <= h_d;
      ovf_q      <= ovf_d;
      ready_q    <= ready_d;
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign o_ready       = ready_q;
  assign o_overflow    = ovf_q;
  assign m_axis_tvalid = head_vld_q;
  assign m_axis_tdata  = head_q[PW-1:0];
  assign m_axis_tuser  = head_q[PW];
  assign m_axis_tlast  = head_q[PW+1];

`ifdef MEDIAN_EGRESS_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + 16'(wr & last_col & last_row);
    drop_cnt_d  = sof_acc ? 16'd0 : drop_cnt_q;
    if (drop && (drop_cnt_d != 16'hFFFF)) drop_cnt_d = drop_cnt_d + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_frame_count = frame_cnt_q;
  assign o_drop_count  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_median_axis_egress.sv
// Bench for median_axis_egress: frames are driven pixel by pixel and the captured stream is compared to a positional model.
module tb_median_axis_egress;

  localparam int KS = 5;

  typedef struct packed {
    logic [7:0] d;
    logic       u;
    logic       l;
  } beat_t;

  logic        clk, rst;
  logic [12:0] img_w, img_h;
  logic        border_mode, pix_vld, sof;
  logic [7:0]  med_pix, raw_pix;
  logic        o_ready, tvalid, tuser, tlast, tready, o_overflow;
  logic [7:0]  tdata;
  logic        rand_en, fixed_rdy, rnd_rdy;
`ifdef MEDIAN_EGRESS_STATS_EN
  logic [15:0] frame_count, drop_count;
`endif

  int total, bad, sent;
  beat_t exp_q[$];
  beat_t obs_q[$];

  median_axis_egress #(.DATA_WIDTH(8), .CHANNELS(1), .KERNEL_SIZE(KS), .FIFO_DEPTH(16)) dut (
    .i_clk(clk), .i_areset(rst), .IMG_WIDTH(img_w), .IMG_HEIGHT(img_h),
    .i_border_mode(border_mode), .i_median_pixel(med_pix), .i_raw_pixel(raw_pix),
    .i_pixel_valid(pix_vld), .i_start_of_frame(sof), .o_ready(o_ready),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tuser(tuser),
    .m_axis_tlast(tlast), .m_axis_tready(tready), .o_overflow(o_overflow)
`ifdef MEDIAN_EGRESS_STATS_EN
    , .o_frame_count(frame_count), .o_drop_count(drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end
  assign tready = rand_en ? rnd_rdy : fixed_rdy;

  always @(negedge clk) begin : monitor
    beat_t b;
    if (!rst && tvalid && tready) begin
      b.d = tdata;
      b.u = tuser;
      b.l = tlast;
      obs_q.push_back(b);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected output value from the pixel's frame position alone.
  function automatic logic [7:0] exp_pix(int x, int y, int w, int h, bit mode, logic [7:0] med, logic [7:0] raw);
    int b;
    b = KS / 2;
    if (x < b || x >= w - b || y < b || y >= h - b) return mode ? raw : 8'h00;
    return med;
  endfunction

  task automatic drive_pix(input bit first, input logic [7:0] med, input logic [7:0] raw, input bit obey);
    int guard;
    guard = 0;
    while (obey && !o_ready && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 3000) begin
      total++; bad++;
      $display("FAIL o_ready_wait timeout got o_ready=%b want 1", o_ready);
    end
    med_pix = med; raw_pix = raw; sof = first; pix_vld = 1'b1;
    @(posedge clk); #1;
    pix_vld = 1'b0; sof = 1'b0;
    sent++;
  endtask

  task automatic drive_frame(input int w, input int h, input int npix, input int keep, input bit mode,
                             input bit obey, input bit fixed, input logic [7:0] fmed, input logic [7:0] fraw);
    img_w = 13'(w); img_h = 13'(h); border_mode = mode;
    for (int i = 0; i < npix; i++) begin
      int x, y;
      logic [7:0] m, r;
      beat_t e;
      x = i % w; y = i / w;
      m = fixed ? fmed : 8'($urandom);
      r = fixed ? fraw : 8'($urandom);
      e.d = exp_pix(x, y, w, h, mode, m, r);
      e.u = (x == 0) && (y == 0);
      e.l = (x == w - 1);
      if (i < keep) exp_q.push_back(e);
      drive_pix(i == 0, m, r, obey);
    end
  endtask

  task automatic wait_drain(output bit ok);
    int g;
    g = 0;
    while ((obs_q.size() < exp_q.size() || tvalid) && g < 5000) begin
      @(posedge clk); #1;
      g++;
    end
    ok = (g < 5000);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL reset_o_ready got %b want 0", o_ready); end
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
    total++; if ({tuser, tlast} !== 2'b00) begin bad++; $display("FAIL reset_tuser_tlast got %b want 00", {tuser, tlast}); end
    total++; if (tdata !== 8'h00) begin bad++; $display("FAIL reset_tdata got %h want 00", tdata); end
    total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got %b want 0", o_overflow); end
`ifdef MEDIAN_EGRESS_STATS_EN
    total++; if ({frame_count, drop_count} !== 32'd0) begin bad++; $display("FAIL reset_stats got %h want 0", {frame_count, drop_count}); end
`endif
    rst = 1'b0;
    #1;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL release_before_edge got %b want 0", o_ready); end
    @(posedge clk); #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL release_first_edge got %b want 1", o_ready); end
  endtask

  task automatic test_border(input bit mode);
    bit ok;
    int n55;
    exp_q.delete(); obs_q.delete();
    rand_en = 1'b0; fixed_rdy = 1'b1;
    drive_frame(8, 6, 48, 48, mode, 1'b1, 1'b1, 8'h55, 8'hAA);
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL border%0d drain timeout got %0d beats want %0d", mode, obs_q.size(), exp_q.size()); end
    total++; if (obs_q.size() !== 48) begin bad++; $display("FAIL border%0d beat_count got %0d want 48", mode, obs_q.size()); end
    n55 = 0;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i].d == 8'h55) n55++;
    total++; if (n55 !== 8) begin bad++; $display("FAIL border%0d interior_count got %0d want 8", mode, n55); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL border%0d beat %0d got d=%h u=%b l=%b want d=%h u=%b l=%b", mode, i,
                 obs_q[i].d, obs_q[i].u, obs_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
      end
    end
  endtask

  task automatic test_random_frames;
    bit ok;
    exp_q.delete(); obs_q.delete();
    rand_en = 1'b1;
    for (int f = 0; f < 5; f++) begin
      int w, h;
      w = $urandom_range(2, 12);
      h = $urandom_range(1, 8);
      drive_frame(w, h, w * h, w * h, 1'($urandom), 1'b1, 1'b0, 8'h00, 8'h00);
    end
    wait_drain(ok);
    rand_en = 1'b0; fixed_rdy = 1'b1;
    total++; if (!ok) begin bad++; $display("FAIL random drain timeout got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL random beat_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL random beat %0d got d=%h u=%b l=%b want d=%h u=%b l=%b", i,
                 obs_q[i].d, obs_q[i].u, obs_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    exp_q.delete(); obs_q.delete();
    rand_en = 1'b0; fixed_rdy = 1'b0; sent = 0;
    fork
      drive_frame(8, 6, 48, 48, 1'($urandom), 1'b1, 1'b0, 8'h00, 8'h00);
      begin
        logic [9:0] held;
        bit have, stable;
        have = 1'b0; stable = 1'b1; held = '0;
        repeat (20) begin
          @(negedge clk);
          if (tvalid) begin
            if (!have) begin held = {tdata, tuser, tlast}; have = 1'b1; end
            else if ({tdata, tuser, tlast} !== held) stable = 1'b0;
          end
        end
        total++; if (!(have && stable)) begin bad++; $display("FAIL hold_stable got have=%b stable=%b want 1 1", have, stable); end
        total++; if (sent !== 13) begin bad++; $display("FAIL ready_fall_occupancy got %0d want 13", sent); end
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL ready_low_when_full got %b want 0", o_ready); end
        @(posedge clk); #1;
        fixed_rdy = 1'b1;
      end
    join
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL backpressure drain timeout got %0d want %0d", obs_q.size(), exp_q.size()); end
    total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL backpressure_overflow got %b want 0", o_overflow); end
    total++; if (obs_q.size() !== 48) begin bad++; $display("FAIL backpressure beat_count got %0d want 48", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL backpressure beat %0d got d=%h u=%b l=%b want d=%h u=%b l=%b", i,
                 obs_q[i].d, obs_q[i].u, obs_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
      end
    end
  endtask

  task automatic test_overflow;
    bit ok;
    exp_q.delete(); obs_q.delete();
    rand_en = 1'b0; fixed_rdy = 1'b0;
    drive_frame(8, 6, 20, 16, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    total++; if (o_overflow !== 1'b1) begin bad++; $display("FAIL overflow_flag got %b want 1", o_overflow); end
`ifdef MEDIAN_EGRESS_STATS_EN
    total++; if (drop_count !== 16'd4) begin bad++; $display("FAIL drop_count got %0d want 4", drop_count); end
`endif
    fixed_rdy = 1'b1;
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL overflow drain timeout got %0d want 16", obs_q.size()); end
    total++; if (obs_q.size() !== 16) begin bad++; $display("FAIL overflow kept_entries got %0d want 16", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL overflow beat %0d got d=%h u=%b l=%b want d=%h u=%b l=%b", i,
                 obs_q[i].d, obs_q[i].u, obs_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
      end
    end
    exp_q.delete(); obs_q.delete();
    drive_frame(8, 6, 48, 48, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    wait_drain(ok);
    total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL overflow_clear got %b want 0", o_overflow); end
    total++; if (obs_q.size() !== 48) begin bad++; $display("FAIL after_overflow beat_count got %0d want 48", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL after_overflow beat %0d got d=%h u=%b l=%b want d=%h u=%b l=%b", i,
                 obs_q[i].d, obs_q[i].u, obs_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
      end
    end
  endtask

  task automatic test_sof_restart;
    bit ok;
    exp_q.delete(); obs_q.delete();
    rand_en = 1'b1;
    drive_frame(8, 6, 11, 11, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    drive_frame(8, 6, 48, 48, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    wait_drain(ok);
    rand_en = 1'b0; fixed_rdy = 1'b1;
    total++; if (!ok) begin bad++; $display("FAIL sof_restart drain timeout got %0d want 59", obs_q.size()); end
    total++; if (obs_q.size() !== 59) begin bad++; $display("FAIL sof_restart beat_count got %0d want 59", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL sof_restart beat %0d got d=%h u=%b l=%b want d=%h u=%b l=%b", i,
                 obs_q[i].d, obs_q[i].u, obs_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    exp_q.delete(); obs_q.delete();
    rand_en = 1'b0; fixed_rdy = 1'b0;
    drive_frame(8, 6, 5, 5, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL queued_before_reset got %b want 1", tvalid); end
    rst = 1'b1;
    #2;
    total++; if ({tvalid, o_ready, tdata} !== 10'd0) begin bad++; $display("FAIL mid_reset_outputs got %h want 0", {tvalid, o_ready, tdata}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_release_ready got %b want 1", o_ready); end
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL mid_reset_fifo_empty got %b want 0", tvalid); end
    exp_q.delete(); obs_q.delete();
    fixed_rdy = 1'b1;
    drive_frame(8, 6, 48, 48, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    wait_drain(ok);
    total++; if (obs_q.size() !== 48) begin bad++; $display("FAIL post_reset beat_count got %0d want 48", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL post_reset beat %0d got d=%h u=%b l=%b want d=%h u=%b l=%b", i,
                 obs_q[i].d, obs_q[i].u, obs_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; sent = 0;
    rst = 1'b1; img_w = '0; img_h = '0; border_mode = 1'b0;
    pix_vld = 1'b0; sof = 1'b0; med_pix = '0; raw_pix = '0;
    rand_en = 1'b0; fixed_rdy = 1'b1; rnd_rdy = 1'b1;
    test_reset;
    test_border(1'b0);
    test_border(1'b1);
    test_random_frames;
    test_backpressure;
    test_overflow;
    test_sof_restart;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
